adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Shares one WIDTH-bit ripple-carry add datapath between two independent requesters using valid/ready handshakes. A 3-state FSM handles operand capture, execution and result hold. Arbitration is round-robin. Sits between board-level input logic (switch/UART decoders) and the result display/consumer logic.

Parameters:
WIDTH, 5, operand width in bits; result is WIDTH+1 bits (carry-out in MSB).

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  synchronous active-low reset, sampled on rising edge of i_clk
i_req0_valid  input  1  requester 0 has operands
i_req0_a  input  WIDTH  requester 0 addend A
i_req0_b  input  WIDTH  requester 0 addend B
o_req0_ready  output  1  requester 0 operands accepted this cycle
i_req1_valid  input  1  requester 1 has operands
i_req1_a  input  WIDTH  requester 1 addend A
i_req1_b  input  WIDTH  requester 1 addend B
o_req1_ready  output  1  requester 1 operands accepted this cycle
o_res_valid  output  1  result available
o_res_data  output  WIDTH+1  {carry_out, sum}
o_res_id  output  1  requester that owns o_res_data (0/1)
i_res_ready  input  1  consumer accepts result

Behaviour:
- Reset: while i_rst_n=0 at a clock edge: state=IDLE, o_res_valid=0, o_res_data=0, o_res_id=0, priority pointer=0, operand registers=0. o_reqN_ready=0 during reset. In-flight operation is discarded with no result.
- Handshake: transfer when valid&ready are both high at a clock edge. Requesters hold valid and operands stable until ready. Consumer may hold i_res_ready high.
- States: IDLE, EXEC, RESULT.
- IDLE: o_reqN_ready is combinational. Only one ready is high at a time.
  - Only one valid: that requester is granted.
  - Both valid: the requester equal to the priority pointer is granted.
  - On handshake: latch A, B and grant id, then go to EXEC. With no valid, stay in IDLE.
- EXEC: both readies are 0. At the edge, o_res_data <= zero-extended A + zero-extended B (WIDTH+1 bits, no overflow loss), o_res_id <= grant id, o_res_valid <= 1. Go to RESULT.
- RESULT: o_res_valid=1; o_res_data and o_res_id are held stable and both readies are 0.
  - On i_res_ready=1: o_res_valid <= 0, priority pointer <= ~o_res_id, go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- Latency: operand handshake at edge N gives o_res_valid=1 after edge N+1. Minimum 3 cycles per operation; the next accept is possible in the cycle after the result handshake.
- Arithmetic boundaries: all-ones + all-ones = {1, all-ones<<1}, e.g. WIDTH=5: 31+31=62 (6'b111110). 0+0=0. The carry-out bit is always present.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1. No requester waits more than one other operation.
- A valid deasserted while in EXEC/RESULT has no effect. A valid raised in EXEC/RESULT waits for IDLE.

Optional Feature:
- Macro ADDER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins when both are valid; the priority pointer is not implemented (not updated, not reset-relevant).
- Undefined (default): round-robin as above.
- The Behaviour section applies unchanged in both builds except the simultaneous-request choice.

Test Plan:
- Reset mid-operation: req0 A=3 B=4 accepted, i_rst_n=0 during EXEC → after reset o_res_valid=0, o_res_data=0. No result ever appears for that request; next req1 5+6 yields 11 id=1.
- Single request: req0 A=12 B=9, i_res_ready=1 → o_req0_ready pulses 1 cycle in IDLE; o_res_valid high 2 edges after accept with data=21, id=0; valid drops after one cycle.
- Overflow boundary: WIDTH=5, A=31 B=31 → o_res_data=62. A=31 B=1 → 32. A=0 B=0 → 0.
- Simultaneous requests: both valid continuously (req0 1+1, req1 2+2) for 4 operations, round-robin build → id sequence 0,1,0,1 with data 2,4,2,4.
- Same stimulus with ADDER_ARB_FIXED_PRIO_EN defined → ids 0,0,0,0 and req1 never ready.
- Backpressure: result 10+5 with i_res_ready=0 for 7 cycles → o_res_valid=1 and data=15 held stable every cycle. Both readies stay 0 despite pending req1 valid; accept occurs on the cycle after i_res_ready=1 handshake.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one shared WIDTH-bit ripple-carry adder serving two
// valid/ready requesters, with a registered {carry, sum} result and its owner id.
// An IDLE -> EXEC -> RESULT FSM runs one operation at a time.
// Ties go round-robin by default. Define ADDER_ARB_FIXED_PRIO_EN to make
// requester 0 always win when both are valid.
module adder_share_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_req1_ready,
  output logic             o_res_valid,
  output logic [WIDTH:0]   o_res_data,
  output logic             o_res_id,
  input  logic             i_res_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             grant;     // requester that would be accepted in IDLE
  logic             accept;
  logic [WIDTH:0]   sum;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is valid
  always_comb grant = !i_req0_valid;
`else
  logic prio_q;

  // Round-robin: the pointer breaks ties, otherwise the lone valid requester wins
  always_comb grant = (i_req0_valid && i_req1_valid) ? prio_q : !i_req0_valid;

  // Pointer moves to the requester that did not own the retired result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                              prio_q <= 1'b0;
    else if (state_q == RESULT && i_res_ready) prio_q <= ~o_res_id;
  end
`endif

  // Readies are only offered in IDLE, out of reset, to the single granted requester
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    if (i_rst_n && state_q == IDLE) begin
      o_req0_ready = i_req0_valid && !grant;
      o_req1_ready = i_req1_valid &&  grant;
    end
  end

  assign accept = o_req0_ready || o_req1_ready;

  // Ripple-carry chain over the captured operands; the carry-out becomes the MSB
  always_comb begin : ripple
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a_q[i] ^ b_q[i] ^ carry;
      carry  = (a_q[i] & b_q[i]) | (carry & (a_q[i] ^ b_q[i]));
    end
    sum[WIDTH] = carry;
  end

  // Next-state logic: capture in IDLE, one compute cycle, hold until consumed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESULT;
      RESULT:  if (i_res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operand capture and result register; reset discards any in-flight operation
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_id    <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= grant ? i_req1_a : i_req0_a;
        b_q  <= grant ? i_req1_b : i_req0_b;
        id_q <= grant;
      end
      if (state_q == EXEC) begin
        o_res_data  <= sum;
        o_res_id    <= id_q;
        o_res_valid <= 1'b1;
      end else if (state_q == RESULT && i_res_ready) begin
        o_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: reset, directed vector table,
// multi-cycle corner sequences and a randomized run against a transaction model.
// Honours ADDER_ARB_FIXED_PRIO_EN to expect fixed instead of round-robin ties.
module tb_adder_share_arbiter;
  localparam int W = 5;
`ifdef ADDER_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_id, res_ready;
  logic [W:0]   res_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .i_req0_a(req0_a), .i_req0_b(req0_b), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_a(req1_a), .i_req1_b(req1_b), .o_req1_ready(req1_ready),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_res_id(res_id), .i_res_ready(res_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past a rising edge; inputs change and outputs are sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE with no competing request and a prompt consumer
  task automatic run_one(input bit id, input int a, input int b, input int exp, input string tag);
    if (id == 1'b0) begin req0_valid = 1'b1; req0_a = W'(a); req0_b = W'(b); end
    else            begin req1_valid = 1'b1; req1_a = W'(a); req1_b = W'(b); end
    #1;
    check({tag, " ready"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check({tag, " exec quiet"}, {req1_ready, req0_ready, res_valid}, 3'b000);
    tick();
    res_ready = 1'b1;
    #1;
    check({tag, " res"}, {res_valid, res_id, res_data}, {1'b1, id, 6'(exp)});
    tick();
    res_ready = 1'b0;
    #1;
    check({tag, " res drop"}, res_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit id;
    int a;
    int b;
    int exp;
  } vec_t;

  vec_t vecs[6];

  // Randomized-run model state
  int  phase;          // 0 free, 1 computing, 2 result pending
  bit  ptr, m_id, win, any, acc0, acc1;
  int  m_data;
  logic [1:0] exp_rdy;
  logic [6:0] exp_res;

  initial begin
    vecs[0] = '{0, 12,  9, 21};
    vecs[1] = '{1, 31, 31, 62};
    vecs[2] = '{0, 31,  1, 32};
    vecs[3] = '{1,  0,  0,  0};
    vecs[4] = '{0, 10,  5, 15};
    vecs[5] = '{1, 17, 14, 31};

    // Reset state, with a requester valid to confirm readies stay low in reset
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd7;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    tick();
    tick();
    check("reset readies", {req1_ready, req0_ready}, 2'b00);
    check("reset res", {res_valid, res_id, res_data}, 8'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Directed table, alternating requesters, covers arithmetic boundaries
    foreach (vecs[i]) run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset during EXEC discards the operation
    req0_valid = 1'b1; req0_a = 5'd3; req0_b = 5'd4;
    #1;
    check("rst_mid accept", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid readies in reset", {req1_ready, req0_ready}, 2'b00);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_mid res cleared", {res_valid, res_data}, 7'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid no ghost result", res_valid, 1'b0);
    end
    run_one(1'b1, 5, 6, 11, "rst_mid next");

    // Continuous dual requests: round-robin alternates, fixed priority always picks 0
    do_reset();
    req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd1;
    req1_valid = 1'b1; req1_a = 5'd2; req1_b = 5'd2;
    res_ready  = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      bit eid;
      eid = FIXED ? 1'b0 : 1'(k % 2);
      check($sformatf("dual%0d grant", k), {req1_ready, req0_ready}, eid ? 2'b10 : 2'b01);
      tick();
      check($sformatf("dual%0d exec quiet", k), {req1_ready, req0_ready}, 2'b00);
      tick();
      check($sformatf("dual%0d res", k), {res_valid, res_id, res_data},
            {1'b1, eid, eid ? 6'd4 : 6'd2});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    tick();

    // Backpressure: result held 7 cycles while req1 waits
    req0_valid = 1'b1; req0_a = 5'd10; req0_b = 5'd5;
    #1;
    check("bp accept", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 5'd2; req1_b = 5'd2;
    #1;
    check("bp exec readies", {req1_ready, req0_ready}, 2'b00);
    tick();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("bp hold%0d", i), {req1_ready, req0_ready, res_valid, res_data},
            {2'b00, 1'b1, 6'd15});
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp release", {res_valid, res_id, res_data}, {1'b1, 1'b0, 6'd15});
    tick();
    res_ready = 1'b0;
    #1;
    check("bp next accept", {req1_ready, req0_ready, res_valid}, 3'b100);
    tick();
    req1_valid = 1'b0;
    tick();
    check("bp next res", {res_valid, res_id, res_data}, {1'b1, 1'b1, 6'd4});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Randomized traffic against a transaction-level model
    do_reset();
    phase = 0; ptr = 1'b0; m_id = 1'b0; m_data = 0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      acc0 = 1'b0; acc1 = 1'b0;
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_a = W'($urandom_range(0, 31)); req0_b = W'($urandom_range(0, 31));
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_a = W'($urandom_range(0, 31)); req1_b = W'($urandom_range(0, 31));
      end
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      any = req0_valid || req1_valid;
      if (req0_valid && req1_valid) win = FIXED ? 1'b0 : ptr;
      else                          win = !req0_valid;
      exp_rdy = (phase == 0 && any) ? (win ? 2'b10 : 2'b01) : 2'b00;
      check("rand readies", {req1_ready, req0_ready}, exp_rdy);
      check("rand res_valid", res_valid, phase == 2);
      if (phase == 2) begin
        exp_res = {m_id, 6'(m_data)};
        check("rand res", {res_id, res_data}, exp_res);
      end
      if (phase == 0) begin
        if (any) begin
          m_id   = win;
          m_data = win ? int'(req1_a) + int'(req1_b) : int'(req0_a) + int'(req0_b);
          acc0   = !win;
          acc1   = win;
          phase  = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else if (res_ready) begin
        phase = 0;
        ptr   = ~m_id;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
